vga_timing_gen: RTL and testbench

//  Source end of the pixel-timing bus (hcount/vcount/hsync/hblnk/vsync/vblnk) that every draw stage consumes.

---
 rtl/vga_timing_gen.sv | 135 +++++++++++++
 tb/tb_vga_timing_gen.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - free-running raster timing generator (XGA 1024x768@60 by default)
// Drives the pixel-timing bus with zero-skew sync/blank flags, a frame start pulse and a frame counter.
module vga_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter int FCNT_W   = 16
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              pix_en,
  input  logic              restart,
  output logic [10:0]       hcount_out,
  output logic [10:0]       vcount_out,
  output logic              hsync_out,
  output logic              hblnk_out,
  output logic              vsync_out,
  output logic              vblnk_out,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2047) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL exceeds 11-bit counter range");
  end
  if (V_TOTAL > 2047) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL exceeds 11-bit counter range");
  end

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_BLNK_BEG = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_BLNK_BEG = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [FCNT_W-1:0] FCNT_ONE = {{(FCNT_W-1){1'b0}}, 1'b1};

  logic [10:0]       r_hcount;
  logic [10:0]       r_vcount;
  logic              r_hsync;
  logic              r_hblnk;
  logic              r_vsync;
  logic              r_vblnk;
  logic              r_frame_start;
  logic [FCNT_W-1:0] r_frame_cnt;

  logic [10:0]       w_hcount_nxt;
  logic [10:0]       w_vcount_nxt;
  logic              w_frame_start_nxt;
  logic [FCNT_W-1:0] w_frame_cnt_nxt;
  logic              w_hsync_nxt;
  logic              w_hblnk_nxt;
  logic              w_vsync_nxt;
  logic              w_vblnk_nxt;
  logic              w_h_last;
  logic              w_v_last;

  assign w_h_last = (r_hcount == H_LAST);
  assign w_v_last = (r_vcount == V_LAST);

  always_comb begin
    w_hcount_nxt      = r_hcount;
    w_vcount_nxt      = r_vcount;
    w_frame_start_nxt = 1'b0;
    w_frame_cnt_nxt   = r_frame_cnt;
    if (restart) begin
      w_hcount_nxt      = 11'd0;
      w_vcount_nxt      = 11'd0;
      w_frame_start_nxt = 1'b1;
    end else if (pix_en) begin
      if (w_h_last) begin
        w_hcount_nxt = 11'd0;
        if (w_v_last) begin
          w_vcount_nxt      = 11'd0;
          w_frame_start_nxt = 1'b1;
          w_frame_cnt_nxt   = r_frame_cnt + FCNT_ONE;
        end else begin
          w_vcount_nxt = r_vcount + 11'd1;
        end
      end else begin
        w_hcount_nxt = r_hcount + 11'd1;
      end
    end
  end

  // Flags are decoded from the next counts so they land together with the counts they describe.
  always_comb begin
    w_hblnk_nxt = (w_hcount_nxt >= H_BLNK_BEG);
    w_hsync_nxt = (w_hcount_nxt >= H_SYNC_BEG) && (w_hcount_nxt < H_SYNC_END);
    w_vblnk_nxt = (w_vcount_nxt >= V_BLNK_BEG);
    w_vsync_nxt = (w_vcount_nxt >= V_SYNC_BEG) && (w_vcount_nxt < V_SYNC_END);
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcount      <= 11'd0;
      r_vcount      <= 11'd0;
      r_hsync       <= 1'b0;
      r_hblnk       <= 1'b0;
      r_vsync       <= 1'b0;
      r_vblnk       <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_hcount      <= w_hcount_nxt;
      r_vcount      <= w_vcount_nxt;
      r_hsync       <= w_hsync_nxt;
      r_hblnk       <= w_hblnk_nxt;
      r_vsync       <= w_vsync_nxt;
      r_vblnk       <= w_vblnk_nxt;
      r_frame_start <= w_frame_start_nxt;
      r_frame_cnt   <= w_frame_cnt_nxt;
    end
  end

  assign hcount_out  = r_hcount;
  assign vcount_out  = r_vcount;
  assign hsync_out   = r_hsync;
  assign hblnk_out   = r_hblnk;
  assign vsync_out   = r_vsync;
  assign vblnk_out   = r_vblnk;
  assign frame_start = r_frame_start;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen on a reduced raster
// Raster: 16+2+3+4 = 25 pixels per line, 6+1+2+1 = 10 lines per frame, 4-bit frame counter.
module tb_vga_timing_gen;

  localparam int HA = 16, HFP = 2, HS = 3, HBP = 4;
  localparam int VA = 6,  VFP = 1, VS = 2, VBP = 1;
  localparam int FW = 4;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;

  logic          pclk = 1'b0;
  logic          rst_n;
  logic          pix_en;
  logic          restart;
  logic [10:0]   hcount_out;
  logic [10:0]   vcount_out;
  logic          hsync_out;
  logic          hblnk_out;
  logic          vsync_out;
  logic          vblnk_out;
  logic          frame_start;
  logic [FW-1:0] frame_cnt;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .FCNT_W(FW)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .pix_en(pix_en), .restart(restart),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_errors = 0;

  // {h, v, hsync, hblnk, vsync, vblnk, frame_start, frame_cnt}
  logic [30:0] sb_q[$];
  int m_h = 0, m_v = 0, m_f = 0;
  int hs_seen = 0, fs_seen = 0;

  function automatic logic [30:0] pack_obs();
    return {hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out, frame_start, frame_cnt};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: advance the model and push what the DUT must show after the edge.
  task automatic step(input logic pe, input logic rs);
    logic fs;
    logic [30:0] e;
    logic [30:0] o;
    @(negedge pclk);
    pix_en  = pe;
    restart = rs;
    fs = 1'b0;
    if (rs) begin
      m_h = 0; m_v = 0; fs = 1'b1;
    end else if (pe) begin
      if (m_h == HT - 1) begin
        m_h = 0;
        if (m_v == VT - 1) begin
          m_v = 0; fs = 1'b1; m_f = (m_f + 1) % (1 << FW);
        end else begin
          m_v = m_v + 1;
        end
      end else begin
        m_h = m_h + 1;
      end
    end
    e = {11'(m_h), 11'(m_v),
         (m_h >= HA + HFP) && (m_h < HA + HFP + HS), (m_h >= HA),
         (m_v >= VA + VFP) && (m_v < VA + VFP + VS), (m_v >= VA),
         fs, FW'(m_f)};
    sb_q.push_back(e);
    @(posedge pclk);
    #1;
    o = pack_obs();
    if (hsync_out) hs_seen++;
    if (frame_start) fs_seen++;
    check("raster", {1'b0, o}, {1'b0, sb_q.pop_front()});
  endtask

  initial begin
    rst_n   = 1'b0;
    pix_en  = 1'b1;
    restart = 1'b0;
    repeat (5) begin
      @(posedge pclk);
      #1;
      check("reset_state", {1'b0, pack_obs()}, 32'd0);
    end
    @(negedge pclk);
    pix_en = 1'b0;
    rst_n  = 1'b1;
    step(1'b1, 1'b0);
    check("first_edge_h", {21'd0, hcount_out}, 32'd1);
    check("first_edge_v", {21'd0, vcount_out}, 32'd0);

    // Rest of line 0 plus the first pixel of line 1.
    hs_seen = 0;
    for (int i = 0; i < HT - 1; i++) step(1'b1, 1'b0);
    check("line_wrap_h", {21'd0, hcount_out}, 32'd0);
    check("line_wrap_v", {21'd0, vcount_out}, 32'd1);
    check("hsync_width", hs_seen, HS);

    fs_seen = 0;
    for (int i = 0; i < HT * (VT - 1); i++) step(1'b1, 1'b0);
    check("frame_start_count", fs_seen, 1);
    check("frame_cnt_one", {28'd0, frame_cnt}, 32'd1);

    for (int i = 0; i < 2 * HT; i++) step(i[0] == 1'b0, 1'b0);
    check("toggle_line_v", {21'd0, vcount_out}, 32'd1);

    for (int i = 0; i < 3 * HT + 10; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("restart_fs", {31'd0, frame_start}, 32'd1);
    check("restart_fcnt", {28'd0, frame_cnt}, 32'd1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("restart_release_fs", {31'd0, frame_start}, 32'd0);

    for (int i = 0; i < HT * VT * 14; i++) step(1'b1, 1'b0);
    check("fcnt_max", {28'd0, frame_cnt}, 32'd15);
    for (int i = 0; i < HT * VT; i++) step(1'b1, 1'b0);
    check("fcnt_wrap", {28'd0, frame_cnt}, 32'd0);

    for (int i = 0; i < HT + 7; i++) step(1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {1'b0, pack_obs()}, 32'd0);
    m_h = 0; m_v = 0; m_f = 0;
    @(negedge pclk);
    pix_en = 1'b0;
    rst_n  = 1'b1;
    for (int i = 0; i < HT + 3; i++) step(1'b1, 1'b0);
    check("resume_h", {21'd0, hcount_out}, 32'd3);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
